// File: rtl/spi_txn_ctrl.sv
// SPI transaction sequencer: command byte plus 0..2^LEN_W-1 data bytes issued back-to-back
// in front of spi_interface. Define SPI_TXN_CTRL_TIMEOUT_EN to add the per-byte watchdog.
module spi_txn_ctrl #(
   parameter int LEN_W          = 8,
   parameter int GAP_CYCLES     = 30,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rw,
   input  logic [7:0]       req_cmd,
   input  logic [LEN_W-1:0] req_len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             err,
   output logic [7:0]       spi_byte_send,
   output logic             spi_send_byte,
   output logic             spi_receive_byte,
   input  logic [7:0]       spi_byte_receive,
   input  logic             spi_system_idle,
   input  logic             spi_cs,
   output logic [2:0]       dbg_state
);

   // Handshakes: a request transfers on a cycle with req_valid & req_ready; a write byte is
   // sampled on an edge where DATA sees wr_valid, and wr_ready pulses in the following cycle.
   // rd_valid is a single-cycle pulse with no backpressure.
   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_WAIT_C = 3'd2,
      ST_DATA   = 3'd3,
      ST_WAIT_D = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               rw_q, rw_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               blank_q, blank_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               req_ready_q, req_ready_d;
   logic               wr_ready_q, wr_ready_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic [7:0]         byte_send_q, byte_send_d;
   logic               send_q, send_d;
   logic               recv_q, recv_d;
   logic               wait_done;
   logic               timeout_hit;

   // The first WAIT cycle is blanked: spi_interface has not yet seen the strobe we just raised.
   assign wait_done = ((state_q == ST_WAIT_C) || (state_q == ST_WAIT_D)) &&
                      !blank_q && spi_system_idle;

`ifdef SPI_TXN_CTRL_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q, to_d;
   logic            err_q, err_d;

   always_comb begin
      to_d        = '0;
      err_d       = err_q;
      timeout_hit = 1'b0;
      if (((state_q == ST_WAIT_C) || (state_q == ST_WAIT_D)) && !wait_done) begin
         if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            err_d       = 1'b1;
         end else begin
            to_d = to_q + TO_W'(1);
         end
      end
      if ((state_q == ST_IDLE) && req_valid && req_ready_q) begin
         err_d = 1'b0;
      end
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      blank_d     = 1'b0;
      gap_d       = gap_q;
      wr_ready_d  = 1'b0;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      byte_send_d = byte_send_q;
      send_d      = 1'b0;
      recv_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end
            if (req_valid && req_ready_q) begin
               rw_d    = req_rw;
               cmd_d   = req_cmd;
               cnt_d   = req_len;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            byte_send_d = cmd_q;
            send_d      = 1'b1;
            blank_d     = 1'b1;
            state_d     = ST_WAIT_C;
         end
         ST_WAIT_C: begin
            if (wait_done) begin
               state_d = (cnt_q == '0) ? ST_DONE : ST_DATA;
            end else if (timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DATA: begin
            if (rw_q) begin
               recv_d  = 1'b1;
               blank_d = 1'b1;
               state_d = ST_WAIT_D;
            end else if (wr_valid) begin
               byte_send_d = wr_data;
               wr_ready_d  = 1'b1;
               send_d      = 1'b1;
               blank_d     = 1'b1;
               state_d     = ST_WAIT_D;
            end
         end
         ST_WAIT_D: begin
            if (wait_done) begin
               if (rw_q) begin
                  rd_data_d  = spi_byte_receive;
                  rd_valid_d = 1'b1;
               end
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_DATA;
            end else if (timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (spi_cs) begin
               gap_d   = GAP_W'(GAP_CYCLES);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE) && (gap_d == '0) && spi_cs;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         rw_q        <= 1'b0;
         cmd_q       <= '0;
         cnt_q       <= '0;
         blank_q     <= 1'b0;
         gap_q       <= '0;
         req_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         byte_send_q <= '0;
         send_q      <= 1'b0;
         recv_q      <= 1'b0;
`ifdef SPI_TXN_CTRL_TIMEOUT_EN
         to_q        <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         blank_q     <= blank_d;
         gap_q       <= gap_d;
         req_ready_q <= req_ready_d;
         wr_ready_q  <= wr_ready_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         byte_send_q <= byte_send_d;
         send_q      <= send_d;
         recv_q      <= recv_d;
`ifdef SPI_TXN_CTRL_TIMEOUT_EN
         to_q        <= to_d;
         err_q       <= err_d;
`endif
      end
   end

   assign req_ready        = req_ready_q;
   assign wr_ready         = wr_ready_q;
   assign rd_data          = rd_data_q;
   assign rd_valid         = rd_valid_q;
   assign busy             = (state_q != ST_IDLE);
   assign spi_byte_send    = byte_send_q;
   assign spi_send_byte    = send_q;
   assign spi_receive_byte = recv_q;
   assign dbg_state        = state_q;

endmodule
